memory_access: RTL and testbench

- Pipelined Y86-64 memory stage. Consumes the M-register fields produced by the execute stage and drives a multi-cycle valid/ack data-memory port.
- Returns m_valM/m_stat for forwarding back to execute and writeback.
- Asserts a stall while an access is outstanding; hazard control freezes F/D/E/M and bubbles W.

---
 rtl/memory_access_if.sv | 31 +++
 rtl/memory_access.sv | 148 ++++++++++++++
 tb/tb_memory_access.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
// Data-memory port between the Y86-64 memory stage (master) and the data memory (slave).
// A single request at a time, held stable by the master until the slave acks.
interface memory_access_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [63:0] dmem_rdata_i;
    logic        dmem_err_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_wdata_o,
        input  dmem_ack_i,
        input  dmem_rdata_i,
        input  dmem_err_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_wdata_o,
        output dmem_ack_i,
        output dmem_rdata_i,
        output dmem_err_i
    );
endinterface

// File: rtl/memory_access.sv
// Pipelined Y86-64 memory stage: decodes the M register, runs one multi-cycle
// valid/ack access at a time, and stalls the pipeline while it is outstanding.
module memory_access #(
    parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0001_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CW       = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [3:0]           M_icode_i,
    input  logic [63:0]          M_valE_i,
    input  logic [63:0]          M_valA_i,
    input  logic [3:0]           M_dstM_i,
    input  logic [2:0]           M_stat_i,
    memory_access_if.master      dmem,
    output logic [63:0]          m_valM_o,
    output logic [2:0]           m_stat_o,
    output logic [3:0]           m_dstM_o,
    output logic                 m_stall_o
);

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_req;
    logic          r_we;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [63:0]   r_valM;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_is_read;
    logic          w_is_write;
    logic          w_mem_op;
    logic [63:0]   w_addr;
    logic          w_in_range;
    logic          w_need_mem;
    logic          w_bad_addr;
    logic [2:0]    w_stat;

    // Decode: pop/ret read from the old stack pointer carried in valA.
    assign w_is_read  = (M_icode_i == IMRMOVQ) || (M_icode_i == IPOPQ) || (M_icode_i == IRET);
    assign w_is_write = (M_icode_i == IRMMOVQ) || (M_icode_i == IPUSHQ) || (M_icode_i == ICALL);
    assign w_mem_op   = w_is_read || w_is_write;
    assign w_addr     = ((M_icode_i == IPOPQ) || (M_icode_i == IRET)) ? M_valA_i : M_valE_i;
    assign w_in_range = (w_addr < MEM_SIZE);
    assign w_need_mem = w_mem_op && (M_stat_i == SAOK) && w_in_range;
    assign w_bad_addr = w_mem_op && (M_stat_i == SAOK) && !w_in_range;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valM  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_need_mem) begin
                        r_addr  <= w_addr;
                        r_we    <= w_is_write;
                        r_wdata <= M_valA_i;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_valM  <= '0;
                        r_req   <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // An ack wins over a timeout landing on the same cycle.
                    if (dmem.dmem_ack_i) begin
                        r_valM  <= (!r_we && !dmem.dmem_err_i) ? dmem.dmem_rdata_i : 64'd0;
                        r_err   <= dmem.dmem_err_i;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_valM  <= '0;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem.dmem_req_o   = r_req;
    assign dmem.dmem_we_o    = r_we;
    assign dmem.dmem_addr_o  = r_addr;
    assign dmem.dmem_wdata_o = r_wdata;

    // Bad addresses are reported in the detect cycle itself, with no request issued.
    always_comb begin
        m_valM_o  = 64'd0;
        w_stat    = M_stat_i;
        m_stall_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                m_stall_o = w_need_mem;
                if (w_bad_addr) w_stat = SADR;
            end
            S_ACCESS: begin
                m_stall_o = 1'b1;
            end
            S_DONE: begin
                m_valM_o = r_valM;
                w_stat   = r_err ? SADR : SAOK;
            end
            default: begin
                m_stall_o = 1'b0;
            end
        endcase
    end

    assign m_stat_o = w_stat;
    assign m_dstM_o = (w_stat == SAOK) ? M_dstM_i : RNONE;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: table of single-cycle decode vectors plus
// hand-written multi-cycle access, error, timeout and reset sequences.
module tb_memory_access;

    localparam logic [63:0] MEM = 64'h0000_0000_0001_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [3:0]  M_icode_i;
    logic [63:0] M_valE_i;
    logic [63:0] M_valA_i;
    logic [3:0]  M_dstM_i;
    logic [2:0]  M_stat_i;
    logic [63:0] m_valM_o;
    logic [2:0]  m_stat_o;
    logic [3:0]  m_dstM_o;
    logic        m_stall_o;

    int tests = 0;
    int fails = 0;

    memory_access_if bus ();

    memory_access #(
        .MEM_SIZE (MEM),
        .TIMEOUT  (16),
        .CW       (5)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .M_icode_i (M_icode_i),
        .M_valE_i  (M_valE_i),
        .M_valA_i  (M_valA_i),
        .M_dstM_i  (M_dstM_i),
        .M_stat_i  (M_stat_i),
        .dmem      (bus.master),
        .m_valM_o  (m_valM_o),
        .m_stat_o  (m_stat_o),
        .m_dstM_o  (m_dstM_o),
        .m_stall_o (m_stall_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstM;
        logic [2:0]  stat;
        logic [2:0]  exp_stat;
        logic [3:0]  exp_dst;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m(input logic [3:0] ic, input logic [63:0] vE, input logic [63:0] vA,
                         input logic [3:0] dst, input logic [2:0] st);
        M_icode_i = ic;
        M_valE_i  = vE;
        M_valA_i  = vA;
        M_dstM_i  = dst;
        M_stat_i  = st;
    endtask

    // Runs one access from the IDLE detect cycle; ack_k = 0 means memory never acks.
    task automatic do_access(input string name, input logic [3:0] ic, input logic [63:0] vE,
                             input logic [63:0] vA, input logic [3:0] dst,
                             input int ack_k, input logic err, input logic [63:0] rdata,
                             input logic exp_we, input logic [63:0] exp_addr,
                             input logic [63:0] exp_valM, input logic [2:0] exp_stat,
                             input logic [3:0] exp_dst, input int exp_reqs);
        int  stalls;
        int  reqs;
        bit  done;
        stalls = 0;
        reqs   = 0;
        done   = 0;
        set_m(ic, vE, vA, dst, 3'd1);
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.dmem_req_o && (reqs + 1 == ack_k)) begin
                bus.dmem_ack_i   = 1'b1;
                bus.dmem_rdata_i = rdata;
                bus.dmem_err_i   = err;
            end else begin
                bus.dmem_ack_i   = 1'b0;
                bus.dmem_rdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
                bus.dmem_err_i   = 1'b0;
            end
            @(negedge clk_i);
            if (m_stall_o) stalls++;
            if (bus.dmem_req_o) begin
                reqs++;
                if (reqs == 1) begin
                    chk({name, " we"}, 64'(bus.dmem_we_o), 64'(exp_we));
                    chk({name, " addr"}, bus.dmem_addr_o, exp_addr);
                    if (exp_we) chk({name, " wdata"}, bus.dmem_wdata_o, vA);
                end
            end
            if (!m_stall_o && c > 0) begin
                done = 1;
                chk({name, " req in done"}, 64'(bus.dmem_req_o), 64'd0);
                chk({name, " valM"}, m_valM_o, exp_valM);
                chk({name, " stat"}, 64'(m_stat_o), 64'(exp_stat));
                chk({name, " dstM"}, 64'(m_dstM_o), 64'(exp_dst));
            end
            tick();
        end
        bus.dmem_ack_i = 1'b0;
        bus.dmem_err_i = 1'b0;
        chk({name, " completed"}, 64'(done), 64'd1);
        chk({name, " stall cycles"}, 64'(stalls), 64'(exp_reqs + 1));
        chk({name, " req cycles"}, 64'(reqs), 64'(exp_reqs));
    endtask

    initial begin
        vecs[0]  = '{4'h1, 64'h0,                   64'h0,  4'hF, 3'd1, 3'd1, 4'hF};
        vecs[1]  = '{4'h3, 64'h2A,                  64'h0,  4'h2, 3'd1, 3'd1, 4'h2};
        vecs[2]  = '{4'h9, 64'h8,                   MEM,    4'h4, 3'd1, 3'd3, 4'hF};
        vecs[3]  = '{4'h5, 64'h100,                 64'h0,  4'h3, 3'd4, 3'd4, 4'hF};
        vecs[4]  = '{4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7,  4'hF, 3'd1, 3'd3, 4'hF};
        vecs[5]  = '{4'hB, 64'h0,                   MEM,    4'h5, 3'd1, 3'd3, 4'hF};
        vecs[6]  = '{4'hA, 64'h10,                  64'h1,  4'hF, 3'd2, 3'd2, 4'hF};
        vecs[7]  = '{4'h0, 64'h0,                   64'h0,  4'hF, 3'd2, 3'd2, 4'hF};
        vecs[8]  = '{4'hC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,  4'h6, 3'd1, 3'd1, 4'h6};
        vecs[9]  = '{4'h8, MEM,                     64'h40, 4'hF, 3'd1, 3'd3, 4'hF};
        vecs[10] = '{4'h6, 64'h1,                   64'h0,  4'h7, 3'd1, 3'd1, 4'h7};

        bus.dmem_ack_i   = 1'b0;
        bus.dmem_rdata_i = 64'h0;
        bus.dmem_err_i   = 1'b0;
        set_m(4'h1, 64'h0, 64'h0, 4'hF, 3'd1);
        rst_n_i = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        chk("in reset req", 64'(bus.dmem_req_o), 64'd0);
        rst_n_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("reset valM", m_valM_o, 64'd0);
        chk("reset stat", 64'(m_stat_o), 64'd1);
        chk("reset stall", 64'(m_stall_o), 64'd0);
        chk("reset req", 64'(bus.dmem_req_o), 64'd0);
        tick();

        // Single-cycle decode vectors: none of these may start an access.
        for (int i = 0; i < 11; i++) begin
            set_m(vecs[i].icode, vecs[i].valE, vecs[i].valA, vecs[i].dstM, vecs[i].stat);
            @(negedge clk_i);
            chk($sformatf("vec%0d stall", i), 64'(m_stall_o), 64'd0);
            chk($sformatf("vec%0d stat", i), 64'(m_stat_o), 64'(vecs[i].exp_stat));
            chk($sformatf("vec%0d valM", i), m_valM_o, 64'd0);
            chk($sformatf("vec%0d dstM", i), 64'(m_dstM_o), 64'(vecs[i].exp_dst));
            tick();
            chk($sformatf("vec%0d req", i), 64'(bus.dmem_req_o), 64'd0);
        end

        do_access("mrmovq", 4'h5, 64'h100, 64'h0, 4'h3, 3, 1'b0, 64'hDEAD_BEEF,
                  1'b0, 64'h100, 64'hDEAD_BEEF, 3'd1, 4'h3, 3);

        // irmovq right after DONE: no stall, no request.
        set_m(4'h3, 64'h77, 64'h0, 4'h1, 3'd1);
        @(negedge clk_i);
        chk("b2b irmovq stall", 64'(m_stall_o), 64'd0);
        chk("b2b irmovq stat", 64'(m_stat_o), 64'd1);
        chk("b2b irmovq dstM", 64'(m_dstM_o), 64'h1);
        tick();
        chk("b2b irmovq req", 64'(bus.dmem_req_o), 64'd0);

        do_access("pushq", 4'hA, 64'h1F8, 64'h55, 4'hF, 1, 1'b0, 64'h1234,
                  1'b1, 64'h1F8, 64'h0, 3'd1, 4'hF, 1);

        do_access("popq err", 4'hB, 64'h208, 64'h200, 4'h3, 2, 1'b1, 64'hABCD,
                  1'b0, 64'h200, 64'h0, 3'd3, 4'hF, 2);

        do_access("popq timeout", 4'hB, 64'h208, 64'h200, 4'h3, 0, 1'b0, 64'h0,
                  1'b0, 64'h200, 64'h0, 3'd3, 4'hF, 16);

        // Stray ack while idle must be ignored.
        set_m(4'h1, 64'h0, 64'h0, 4'hF, 3'd1);
        bus.dmem_ack_i   = 1'b1;
        bus.dmem_rdata_i = 64'hFEED;
        tick();
        bus.dmem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("stray ack req", 64'(bus.dmem_req_o), 64'd0);
        chk("stray ack stall", 64'(m_stall_o), 64'd0);
        chk("stray ack valM", m_valM_o, 64'd0);
        tick();

        // Asynchronous reset in the middle of ACCESS.
        set_m(4'h5, 64'h300, 64'h0, 4'h2, 3'd1);
        tick();
        @(negedge clk_i);
        chk("pre-reset req", 64'(bus.dmem_req_o), 64'd1);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("async reset req", 64'(bus.dmem_req_o), 64'd0);
        set_m(4'h1, 64'h0, 64'h0, 4'hF, 3'd1);
        tick();
        rst_n_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("post-reset stall", 64'(m_stall_o), 64'd0);
        chk("post-reset req", 64'(bus.dmem_req_o), 64'd0);
        chk("post-reset stat", 64'(m_stat_o), 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
